// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter driving the select of a 4:1 mux, with a
//            registered one-hot grant and an idle cycle between owners.
//            Optional hold timeout enabled by MUX4_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       busy
);

    localparam logic [0:0] C_IDLE  = 1'b0;
    localparam logic [0:0] C_GRANT = 1'b1;

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_range
        $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] s_q, s_d;
    logic       busy_q, busy_d;

    logic       w_found;
    logic [1:0] w_pick;
    logic [1:0] w_cand;
    logic       w_release;

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       w_timeout;

    // Only preempt when someone else is actually waiting.
    assign w_timeout = (hold_q == C_HOLD_LAST) && ((req & ~gnt_q) != 4'b0000);
`else
    logic       w_timeout;

    assign w_timeout = 1'b0;
`endif

    assign w_release = ~req[s_q] | w_timeout;

    // Scan downward from ptr+3 so the candidate closest to ptr wins last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = ptr_q;
        w_cand  = ptr_q;
        for (int off = 3; off >= 0; off--) begin
            w_cand = ptr_q + 2'(off);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
            ptr_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            s_q     <= 2'b00;
            busy_q  <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
`ifdef MUX4_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            C_IDLE: begin
                if (w_found) begin
                    state_d = C_GRANT;
                end
            end
            C_GRANT: begin
                if (w_release) begin
                    state_d = C_IDLE;
                    ptr_d   = s_q + 2'd1;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    // Counter sits at zero in IDLE so it is already clear on entry to GRANT.
    always_comb begin
        hold_d = hold_q;
        if (state_q == C_IDLE) begin
            hold_d = 8'd0;
        end else if (hold_q != C_HOLD_LAST) begin
            hold_d = hold_q + 8'd1;
        end
    end
`endif

    always_comb begin
        gnt_d  = gnt_q;
        s_d    = s_q;
        busy_d = busy_q;
        if ((state_q == C_IDLE) && w_found) begin
            gnt_d  = 4'b0001 << w_pick;
            s_d    = w_pick;
            busy_d = 1'b1;
        end else if ((state_q == C_GRANT) && w_release) begin
            gnt_d  = 4'b0000;
            busy_d = 1'b0;
        end
    end

    assign gnt  = gnt_q;
    assign s    = s_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4-to-1 gate-level multiplexer (data inputs j, k, l, m) between four requesters. It grants one requester at a time with a registered one-hot grant and drives the mux select `s` to match. Handoff between owners passes through an idle cycle, so `s` only changes while no grant is active. It sits directly in front of the multiplexer's `s` input.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester waits. Range 2..255. Used only with `MUX4_ARB_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request lines. Bit 0 = source j, bit 1 = k, bit 2 = l, bit 3 = m. Level-sensitive; the requester holds its bit while it uses the mux.
- `gnt` output 4: one-hot grant, registered. All zero when idle.
- `s` output 2: mux select, registered. Equals the index of the current or last owner.
- `busy` output 1: high while a grant is active.

## Operation
- State `ptr` (2 bits) is the highest-priority index for the next arbitration.
- FSM has two states:
  - IDLE
    - If `req == 0`, stay in IDLE.
    - Otherwise pick the first index i with `req[i]=1`, searching `ptr, ptr+1, ptr+2, ptr+3` mod 4.
    - At that edge: `gnt <= 1<<i`, `s <= i`, `busy <= 1`, go to GRANT.
  - GRANT
    - If `req[owner]` is sampled low: `gnt <= 0`, `busy <= 0`, `ptr <= owner+1` (mod 4, so 3 wraps to 0), go to IDLE.
    - Otherwise hold all outputs.
- `s` keeps its value in IDLE. It never changes while `gnt != 0`.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle.
- `gnt` is never multi-hot. `busy == |gnt` at all times.
- Reset values: `gnt=4'b0000`, `s=2'b00`, `busy=0`, `ptr=2'b00`, state IDLE, hold counter 0.

## Timing
- Grant latency: a request sampled at edge n produces `gnt`/`s` valid after edge n (one cycle from assertion).
- Release latency: `req[owner]` sampled low at edge n gives `gnt=0` after edge n.
- Minimum turnaround between two different owners is 1 idle cycle. Back-to-back grants therefore occupy at least one cycle of `gnt=0`.
- Single requester re-asserting immediately after release:
  - It is regranted after the idle cycle.
  - `ptr` has already moved past it, but no other requester competes, so it still wins.
- Simultaneous release and new requests at the same edge: release wins. Arbitration happens at the following edge using the updated `ptr`.
- Reset asserted mid-grant: at the next edge all outputs and `ptr` return to their reset values, regardless of `req`.
- `rst` has priority over every other transition.

## Configuration
- `MUX4_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals `MAX_HOLD-1` and any other `req` bit is high, the grant is forcibly released at that edge: `gnt <= 0`, `ptr <= owner+1`, go to IDLE.
  - The owner has then held `gnt` for exactly `MAX_HOLD` cycles.
  - If no other request is pending, the counter saturates and the grant continues.
- `MUX4_ARB_TIMEOUT_EN` undefined:
  - The counter logic is absent and `MAX_HOLD` is ignored.
  - A grant persists until the owner drops `req`.

## Test plan
- Reset: `rst=1` for 2 cycles with `req=4'b1111` -> `gnt=0000`, `s=00`, `busy=0` throughout. Release reset -> one edge later `gnt=0001`, `s=00`.
- Single requester: `req=0100` -> after 1 edge `gnt=0100`, `s=10`, `busy=1`. Drop `req` -> next edge `gnt=0000`, `busy=0`, `s` stays `10`.
- Rotation: `req=1111`, each owner drops its bit for 1 cycle after 3 grant cycles -> grant order 0001, 0010, 0100, 1000, 0001, with one `gnt=0000` cycle between each and `s` tracking 00, 01, 10, 11, 00.
- Wrap-around: grant index 2, release, then `req=1001` -> next grant `1000` (`ptr=3`). Release, keep `req=1001` -> next grant `0001` (`ptr` wrapped to 0).
- Timeout (macro defined, `MAX_HOLD=4`): `req=0011` held constantly -> `gnt=0001` for exactly 4 cycles, 1 idle, `gnt=0010` for 4, 1 idle, repeat. Same stimulus without the macro -> `gnt=0001` indefinitely. With the macro and `req=0001` alone -> grant never preempted.
- Reset mid-grant: owner 3 granted, assert `rst` for 1 cycle -> `gnt=0000`, `s=00`, `busy=0` after that edge. With `req=1010` still high afterward -> next grant `0010` (`ptr=0`).
